task_sequencer: RTL and testbench

TASK_SEQUENCER -- requirements
Module: task_sequencer

---
 rtl/task_sequencer_pkg.sv | 16 +
 rtl/task_sequencer_if.sv | 39 +++
 rtl/task_sequencer_sat_counter.sv | 24 ++
 rtl/task_sequencer.sv | 113 +++++++++++
 tb/tb_task_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/task_sequencer_pkg.sv
// Shared definitions for the task sequencer.
// Holds the controller state encoding (also exported on the debug state
// port of the interface) and the default sequence shape constants.
package task_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      WAIT_STEP = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam int DEFAULT_LAST_TASK   = 7;
   localparam int DEFAULT_HOLD_CYCLES = 4;

endpackage

// File: rtl/task_sequencer_if.sv
// Control/status bundle between the sequence owner and task_sequencer.
// master : drives start/step_mode/step/abort/result_in, observes status.
// slave  : the sequencer itself.
// Handshake: start, step and abort are level-sampled on every rising clk
// edge; start is honoured only in IDLE, step only in WAIT_STEP, abort
// always. done and result_valid are single-cycle pulses, no back-pressure.
// state is a debug view of the controller state register.
interface task_sequencer_if #(
   parameter int W = 8
);
   import task_sequencer_pkg::*;

   logic         start;
   logic         step_mode;
   logic         step;
   logic         abort;
   logic [W-1:0] result_in;
   logic [3:0]   task_select;
   logic         task_valid;
   logic         busy;
   logic         done;
   logic [W-1:0] last_result;
   logic         result_valid;
   logic [W-1:0] run_cycles;
   state_t       state;

   modport master (
      output start, step_mode, step, abort, result_in,
      input  task_select, task_valid, busy, done, last_result,
             result_valid, run_cycles, state
   );

   modport slave (
      input  start, step_mode, step, abort, result_in,
      output task_select, task_valid, busy, done, last_result,
             result_valid, run_cycles, state
   );

endinterface

// File: rtl/task_sequencer_sat_counter.sv
// Saturating up-counter used for the RUN cycle count.
// Ports: clk, reset_synchronous (sync, active-high), clear (sync clear,
// wins over inc), inc (count enable), count (holds at all-ones).
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_synchronous,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset_synchronous) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/task_sequencer.sv
// Task sequencer: steps a task index 0..LAST_TASK, presenting each task
// for HOLD_CYCLES cycles, either advancing automatically or waiting for a
// step pulse between tasks. result_in is captured on the last hold cycle
// of every task.
// Ports: clk, reset_synchronous (sync, active-high), bus (slave modport of
// task_sequencer_if; its W must match this module's W).
module task_sequencer
   import task_sequencer_pkg::*;
#(
   parameter int W           = 8,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int LAST_TASK   = DEFAULT_LAST_TASK
) (
   input  logic           clk,
   input  logic           reset_synchronous,
   task_sequencer_if.slave bus
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [3:0] LAST_SEL  = 4'(LAST_TASK);

   state_t       state;
   logic [7:0]   hold_cnt;
   logic [3:0]   task_select;
   logic [W-1:0] last_result;
   logic         result_valid;
   logic [W-1:0] run_cycles;

   logic last_hold;
   logic cnt_clear;
   logic cnt_inc;

   assign last_hold = (state == RUN) && (hold_cnt == HOLD_LAST);
   // Clear only when the start is actually accepted (abort wins).
   assign cnt_clear = (state == IDLE) && bus.start && !bus.abort;
   assign cnt_inc   = (state == RUN);

   sat_counter #(.W(W)) u_run_cnt (
      .clk               (clk),
      .reset_synchronous (reset_synchronous),
      .clear             (cnt_clear),
      .inc               (cnt_inc),
      .count             (run_cycles)
   );

   always_ff @(posedge clk) begin
      if (reset_synchronous) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         task_select  <= '0;
         last_result  <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         // Capture is independent of abort so a coinciding abort still
         // records the finishing task's result.
         if (last_hold) begin
            last_result  <= bus.result_in;
            result_valid <= 1'b1;
         end

         if (bus.abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     task_select <= '0;
                     hold_cnt    <= '0;
                     state       <= RUN;
                  end
               end
               RUN: begin
                  hold_cnt <= hold_cnt + 8'd1;
                  if (last_hold) begin
                     if (task_select == LAST_SEL) begin
                        state <= DONE;
                     end else if (!bus.step_mode) begin
                        task_select <= task_select + 4'd1;
                        hold_cnt    <= '0;
                     end else begin
                        state <= WAIT_STEP;
                     end
                  end
               end
               WAIT_STEP: begin
                  if (bus.step) begin
                     task_select <= task_select + 4'd1;
                     hold_cnt    <= '0;
                     state       <= RUN;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.task_select  = task_select;
   assign bus.task_valid   = (state == RUN);
   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE);
   assign bus.last_result  = last_result;
   assign bus.result_valid = result_valid;
   assign bus.run_cycles   = run_cycles;
   assign bus.state        = state;

endmodule

// File: tb/tb_task_sequencer.sv
// Bench for task_sequencer: two instances (HOLD_CYCLES=4 and 1) share the
// same stimulus; both are compared every cycle against a reference model,
// plus a table of auto-mode checkpoints and directed corner sequences.
module tb_task_sequencer;
   import task_sequencer_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       in_rst       = 1'b1;
   logic       in_start     = 1'b0;
   logic       in_step_mode = 1'b0;
   logic       in_step      = 1'b0;
   logic       in_abort     = 1'b0;
   logic [7:0] in_result    = 8'h00;

   task_sequencer_if #(.W(8)) bus4 ();
   task_sequencer_if #(.W(8)) bus1 ();

   assign bus4.start = in_start;      assign bus1.start = in_start;
   assign bus4.step_mode = in_step_mode; assign bus1.step_mode = in_step_mode;
   assign bus4.step = in_step;        assign bus1.step = in_step;
   assign bus4.abort = in_abort;      assign bus1.abort = in_abort;
   assign bus4.result_in = in_result; assign bus1.result_in = in_result;

   task_sequencer #(.W(8), .HOLD_CYCLES(4), .LAST_TASK(7)) u_dut4 (
      .clk(clk), .reset_synchronous(in_rst), .bus(bus4));
   task_sequencer #(.W(8), .HOLD_CYCLES(1), .LAST_TASK(7)) u_dut1 (
      .clk(clk), .reset_synchronous(in_rst), .bus(bus1));

   logic [25:0] obs4, obs1;
   assign obs4 = {bus4.state, bus4.task_select, bus4.task_valid, bus4.busy, bus4.done,
                  bus4.run_cycles, bus4.last_result, bus4.result_valid};
   assign obs1 = {bus1.state, bus1.task_select, bus1.task_valid, bus1.busy, bus1.done,
                  bus1.run_cycles, bus1.last_result, bus1.result_valid};

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 presenting a task, 2 waiting for step, 3 finishing
   int m_phase[2], m_task[2], m_elapsed[2], m_runs[2], m_last[2];
   bit m_rv[2];
   int hold_of[2] = '{4, 1};

   function automatic logic [25:0] model_obs(int i);
      logic [1:0] ph;
      ph = 2'(m_phase[i]);
      return {ph, 4'(m_task[i]), (m_phase[i] == 1), (m_phase[i] != 0),
              (m_phase[i] == 3), 8'(m_runs[i]), 8'(m_last[i]), m_rv[i]};
   endfunction

   function automatic void model_step(int i);
      bit finishing;
      if (in_rst) begin
         m_phase[i] = 0; m_task[i] = 0; m_elapsed[i] = 0;
         m_runs[i] = 0;  m_last[i] = 0; m_rv[i] = 0;
         return;
      end
      m_rv[i] = 0;
      case (m_phase[i])
         0: if (in_start && !in_abort) begin
               m_task[i] = 0; m_elapsed[i] = 0; m_runs[i] = 0; m_phase[i] = 1;
            end
         1: begin
               finishing = (m_elapsed[i] + 1 == hold_of[i]);
               m_runs[i] = (m_runs[i] < 255) ? m_runs[i] + 1 : 255;
               m_elapsed[i]++;
               if (finishing) begin
                  m_last[i] = int'(in_result);
                  m_rv[i]   = 1;
               end
               if (in_abort) m_phase[i] = 0;
               else if (finishing) begin
                  if (m_task[i] == 7) m_phase[i] = 3;
                  else if (!in_step_mode) begin
                     m_task[i]++; m_elapsed[i] = 0;
                  end else m_phase[i] = 2;
               end
            end
         2: if (in_abort) m_phase[i] = 0;
            else if (in_step) begin
               m_task[i]++; m_elapsed[i] = 0; m_phase[i] = 1;
            end
         default: m_phase[i] = 0;
      endcase
   endfunction

   // ---------------- scoreboard helpers ----------------
   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endfunction

   task automatic check_models();
      checks++;
      if (obs4 !== model_obs(0)) begin
         errors++;
         $display("FAIL model_hold4 t=%0t: got=%h expected=%h", $time, obs4, model_obs(0));
      end
      checks++;
      if (obs1 !== model_obs(1)) begin
         errors++;
         $display("FAIL model_hold1 t=%0t: got=%h expected=%h", $time, obs1, model_obs(1));
      end
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs; on return outputs reflect the next cycle.
   task automatic cyc(input logic s, input logic sm, input logic st, input logic ab,
                      input logic [7:0] ri, input logic r);
      in_start = s; in_step_mode = sm; in_step = st; in_abort = ab;
      in_result = ri; in_rst = r;
      @(negedge clk);
      check_models();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   // ---------------- auto-mode checkpoint table ----------------
   typedef struct {
      int         cyc;
      logic [3:0] ts;
      logic       tv;
      logic       dn;
      logic       by;
      logic [7:0] rc;
      logic [7:0] lr;
      logic       rv;
   } auto_vec_t;

   auto_vec_t av[11];

   initial begin
      av[0]  = '{1,  4'd0, 1'b1, 1'b0, 1'b1, 8'd0,  8'd0,  1'b0};
      av[1]  = '{4,  4'd0, 1'b1, 1'b0, 1'b1, 8'd3,  8'd0,  1'b0};
      av[2]  = '{5,  4'd1, 1'b1, 1'b0, 1'b1, 8'd4,  8'd4,  1'b1};
      av[3]  = '{12, 4'd2, 1'b1, 1'b0, 1'b1, 8'd11, 8'd8,  1'b0};
      av[4]  = '{13, 4'd3, 1'b1, 1'b0, 1'b1, 8'd12, 8'hA3, 1'b1};
      av[5]  = '{14, 4'd3, 1'b1, 1'b0, 1'b1, 8'd13, 8'hA3, 1'b0};
      av[6]  = '{29, 4'd7, 1'b1, 1'b0, 1'b1, 8'd28, 8'd28, 1'b1};
      av[7]  = '{32, 4'd7, 1'b1, 1'b0, 1'b1, 8'd31, 8'd28, 1'b0};
      av[8]  = '{33, 4'd7, 1'b0, 1'b1, 1'b1, 8'd32, 8'd32, 1'b1};
      av[9]  = '{34, 4'd7, 1'b0, 1'b0, 1'b0, 8'd32, 8'd32, 1'b0};
      av[10] = '{35, 4'd7, 1'b0, 1'b0, 1'b0, 8'd32, 8'd32, 1'b0};

      @(posedge clk);
      #1;

      // reset state
      cyc(0, 0, 0, 0, 8'h00, 1);
      chk("rst_task_select", 32'(bus4.task_select), 0);
      chk("rst_task_valid", 32'(bus4.task_valid), 0);
      chk("rst_busy", 32'(bus4.busy), 0);
      chk("rst_done", 32'(bus4.done), 0);
      chk("rst_last_result", 32'(bus4.last_result), 0);
      chk("rst_result_valid", 32'(bus4.result_valid), 0);
      chk("rst_run_cycles", 32'(bus4.run_cycles), 0);
      chk("rst_state", 32'(bus4.state), 32'(IDLE));

      // auto mode with capture of 8'hA3 at end of task 2
      for (int c = 0; c <= 35; c++) begin
         cyc(c == 0, 0, 0, 0, (c == 12) ? 8'hA3 : 8'(c), 0);
         foreach (av[j]) begin
            if (av[j].cyc == c + 1) begin
               chk($sformatf("auto_c%0d_ts", c + 1), 32'(bus4.task_select), 32'(av[j].ts));
               chk($sformatf("auto_c%0d_tv", c + 1), 32'(bus4.task_valid), 32'(av[j].tv));
               chk($sformatf("auto_c%0d_done", c + 1), 32'(bus4.done), 32'(av[j].dn));
               chk($sformatf("auto_c%0d_busy", c + 1), 32'(bus4.busy), 32'(av[j].by));
               chk($sformatf("auto_c%0d_runc", c + 1), 32'(bus4.run_cycles), 32'(av[j].rc));
               chk($sformatf("auto_c%0d_lres", c + 1), 32'(bus4.last_result), 32'(av[j].lr));
               chk($sformatf("auto_c%0d_rv", c + 1), 32'(bus4.result_valid), 32'(av[j].rv));
            end
         end
      end

      // manual stepping on the HOLD_CYCLES=1 instance
      cyc(1, 1, 0, 0, 8'h11, 0);
      chk("man_t0_valid", 32'(bus1.task_valid), 1);
      chk("man_t0_sel", 32'(bus1.task_select), 0);
      cyc(0, 1, 0, 0, 8'h12, 0);
      chk("man_wait0_valid", 32'(bus1.task_valid), 0);
      chk("man_wait0_state", 32'(bus1.state), 32'(WAIT_STEP));
      for (int k = 1; k <= 7; k++) begin
         cyc(0, 1, 0, 0, 8'(k), 0);
         chk($sformatf("man_k%0d_wait_valid", k), 32'(bus1.task_valid), 0);
         chk($sformatf("man_k%0d_wait_busy", k), 32'(bus1.busy), 1);
         chk($sformatf("man_k%0d_wait_sel", k), 32'(bus1.task_select), 32'(k - 1));
         cyc(0, 1, 1, 0, 8'(k + 16), 0);
         chk($sformatf("man_k%0d_run_valid", k), 32'(bus1.task_valid), 1);
         chk($sformatf("man_k%0d_run_sel", k), 32'(bus1.task_select), 32'(k));
         if (k == 1) begin
            // step arrived while the hold-4 instance was still in RUN
            chk("step_in_run_sel", 32'(bus4.task_select), 0);
            chk("step_in_run_valid", 32'(bus4.task_valid), 1);
         end
         cyc(0, 1, 0, 0, 8'(k + 32), 0);
         if (k < 7) chk($sformatf("man_k%0d_back_valid", k), 32'(bus1.task_valid), 0);
         else chk("man_done", 32'(bus1.done), 1);
      end
      cyc(0, 1, 0, 0, 8'h00, 0);
      chk("man_idle_busy", 32'(bus1.busy), 0);
      chk("man_idle_sel_hold", 32'(bus1.task_select), 7);
      cyc(0, 0, 0, 1, 8'h00, 0);
      cyc(0, 0, 0, 0, 8'h00, 0);

      // abort during task 3
      for (int c = 0; c <= 14; c++) cyc(c == 0, 0, 0, c == 14, 8'h3C, 0);
      chk("abort_busy", 32'(bus4.busy), 0);
      chk("abort_valid", 32'(bus4.task_valid), 0);
      chk("abort_done", 32'(bus4.done), 0);
      for (int c = 0; c < 5; c++) begin
         cyc(0, 0, 0, 0, 8'h00, 0);
         chk($sformatf("abort_nodone_%0d", c), 32'(bus4.done), 0);
      end
      cyc(1, 0, 0, 0, 8'h00, 0);
      chk("restart_sel", 32'(bus4.task_select), 0);
      chk("restart_runc", 32'(bus4.run_cycles), 0);
      chk("restart_valid", 32'(bus4.task_valid), 1);
      cyc(0, 0, 0, 1, 8'h00, 0);
      cyc(0, 0, 0, 0, 8'h00, 0);

      // reset during task 5
      for (int c = 0; c <= 22; c++) cyc(c == 0, 0, 0, 0, 8'h5A, c == 22);
      chk("midrst_sel", 32'(bus4.task_select), 0);
      chk("midrst_valid", 32'(bus4.task_valid), 0);
      chk("midrst_busy", 32'(bus4.busy), 0);
      chk("midrst_lres", 32'(bus4.last_result), 0);
      chk("midrst_runc", 32'(bus4.run_cycles), 0);
      chk("midrst_rv", 32'(bus4.result_valid), 0);

      // start while busy is ignored
      for (int c = 0; c <= 3; c++) cyc(c == 0 || c == 3, 0, 0, 0, 8'h00, 0);
      chk("busy_start_sel", 32'(bus4.task_select), 0);
      chk("busy_start_runc", 32'(bus4.run_cycles), 3);
      cyc(0, 0, 0, 0, 8'h00, 0);
      chk("busy_start_adv", 32'(bus4.task_select), 1);
      cyc(0, 0, 0, 1, 8'h00, 0);

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(59, 0) == 0) in_step_mode = ~in_step_mode;
         cyc($urandom_range(5, 0) == 0, in_step_mode, $urandom_range(2, 0) == 0,
             $urandom_range(39, 0) == 0, 8'($urandom_range(255, 0)),
             $urandom_range(199, 0) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
